// File: rtl/tff_count_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tff_count_sequencer
// Summary  : Drives the toggle enables of an external T flip-flop bank so it
//            counts up or down to a programmed target, with a stuck-bank check.
// Revision : 1.0
// ============================================================================
module tff_count_sequencer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             dir,
    input  logic [WIDTH-1:0] target,
    input  logic             pause,
    input  logic             abort,
    input  logic [WIDTH-1:0] q_in,
    output logic [WIDTH-1:0] t_out,
    output logic             tff_rst,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam logic [2:0] c_idle  = 3'd0;
    localparam logic [2:0] c_clear = 3'd1;
    localparam logic [2:0] c_run   = 3'd2;
    localparam logic [2:0] c_done  = 3'd3;
    localparam logic [2:0] c_err   = 3'd4;

    // The step that would bring the counter to 2^WIDTH; a working bank always
    // matches before this many steps have been issued.
    localparam logic [WIDTH:0] c_last_step = {1'b0, {WIDTH{1'b1}}};

    logic [2:0]       r_state;
    logic [2:0]       w_state_nxt;
    logic [WIDTH-1:0] r_target;
    logic             r_dir;
    logic [WIDTH:0]   r_steps;
    logic             w_match;
    logic             w_step;
    logic [WIDTH-1:0] w_carry;
    logic [WIDTH-1:0] w_toggle;

    assign w_match = (q_in == r_target);

    // Ripple prefix: a bit toggles when every lower bit is 1 (up) or 0 (down).
    always_comb begin
        w_carry    = '0;
        w_carry[0] = 1'b1;
        for (int i = 1; i < WIDTH; i++) begin
            w_carry[i] = w_carry[i-1] & (q_in[i-1] ^ r_dir);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_step      = 1'b0;
        w_toggle    = '0;
        case (r_state)
            c_idle: begin
                if (start) begin
                    w_state_nxt = c_clear;
                end
            end
            c_clear: begin
                w_state_nxt = abort ? c_idle : c_run;
            end
            c_run: begin
                if (abort) begin
                    w_state_nxt = c_idle;
                end else if (w_match) begin
                    w_state_nxt = c_done;
                end else if (!pause) begin
                    w_step   = 1'b1;
                    w_toggle = w_carry;
                    if (r_steps == c_last_step) begin
                        w_state_nxt = c_err;
                    end
                end
            end
            c_done: begin
                w_state_nxt = c_idle;
            end
            c_err: begin
                if (abort) begin
                    w_state_nxt = c_idle;
                end
            end
            default: begin
                w_state_nxt = c_idle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= c_idle;
            r_target <= '0;
            r_dir    <= 1'b0;
            r_steps  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == c_idle && start) begin
                r_target <= target;
                r_dir    <= dir;
                r_steps  <= '0;
            end else if (w_step) begin
                r_steps <= r_steps + 1'b1;
            end
        end
    end

    // Outputs are forced quiet while rst is high, even before the state settles.
    assign t_out   = rst ? '0 : w_toggle;
    assign tff_rst = rst | (r_state == c_clear);
    assign busy    = ~rst & ((r_state == c_clear) | (r_state == c_run));
    assign done    = ~rst & (r_state == c_done);
    assign err     = ~rst & (r_state == c_err);

endmodule
`default_nettype wire
